perf_trace_unit: RTL and testbench

Non-intrusive performance-counter and commit-trace block for the RISC-V pipelined core. It sits beside the datapath and consumes its retire and debug strobes. It maintains cycle, retired-instruction, taken-branch, stall and dropped-trace counters, and streams one trace record per retired instruction over a valid/ready interface to a trace sink or bench checker. It stops counting on EBREAK, so software loops self-report CPI without bench-side counting.

---
 rtl/perf_trace_unit_pkg.sv | 29 ++
 rtl/perf_trace_unit_trace_fifo.sv | 74 +++++++
 rtl/perf_trace_unit.sv | 156 +++++++++++++++
 tb/tb_perf_trace_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_trace_unit_pkg.sv
// perf_trace_unit_pkg
// Shared definitions for the performance-counter / commit-trace block:
// the EBREAK encoding that halts counting, the counter read-address map
// and the packed trace record carried through the trace FIFO.
package perf_trace_unit_pkg;

    localparam logic [31:0] EBREAK_ENC = 32'h00100073;

    localparam logic [2:0] PERF_ADDR_CYCLE   = 3'd0;
    localparam logic [2:0] PERF_ADDR_INSTRET = 3'd1;
    localparam logic [2:0] PERF_ADDR_BRANCH  = 3'd2;
    localparam logic [2:0] PERF_ADDR_STALL   = 3'd3;
    localparam logic [2:0] PERF_ADDR_DROP    = 3'd4;
    localparam logic [2:0] PERF_ADDR_OCC     = 3'd5;
    localparam logic [2:0] PERF_ADDR_HALTED  = 3'd6;
    localparam logic [2:0] PERF_ADDR_ZERO    = 3'd7;

    // 65-bit record: {pc, instr, branch}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        branch;
    } trace_rec_t;

    function automatic logic is_ebreak(input logic [31:0] instr);
        return instr == EBREAK_ENC;
    endfunction

endpackage

// File: rtl/perf_trace_unit_trace_fifo.sv
// trace_fifo
// Parameterized synchronous FIFO, reusable by any debug sink.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset (pointers only)
//   clr_i            : synchronous flush, wins over push/pop
//   push_i, wdata_i  : write request and data (ignored when full unless popping)
//   pop_i            : remove head entry (ignored when empty)
//   rdata_o          : head entry, forced to 0 while empty
//   full_o, empty_o  : status
//   count_o          : occupancy, 0..DEPTH
// DEPTH must be a power of two >= 2. Pointers carry one extra bit so that
// full (same index, different lap) and empty (identical pointers) differ.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 65
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries data only; validity comes from the pointers.
    always_ff @(posedge clock) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/perf_trace_unit.sv
// perf_trace_unit
// Non-intrusive performance counters and commit trace for the pipelined core.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   enable, clear            : counting enable, synchronous flush pulse
//   retire_valid/pc/instr    : retire strobe and retiring instruction
//   branch_taken, stall      : pipeline event strobes
//   rd_en, rd_addr           : counter read request (1-cycle latency)
//   rd_valid, rd_data        : registered read response
//   trace_valid/ready        : trace stream handshake
//   trace_pc/instr/branch    : head trace record (0 while empty)
//   halted                   : sticky, set after EBREAK retires
module perf_trace_unit
    import perf_trace_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    input  logic        retire_valid,
    input  logic [31:0] retire_pc,
    input  logic [31:0] retire_instr,
    input  logic        branch_taken,
    input  logic        stall,
    input  logic        rd_en,
    input  logic [2:0]  rd_addr,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_instr,
    output logic        trace_branch,
    output logic        halted
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cycle_q,   cycle_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic [CNT_WIDTH-1:0] branch_q,  branch_d;
    logic [CNT_WIDTH-1:0] stall_q,   stall_d;
    logic [CNT_WIDTH-1:0] drop_q,    drop_d;
    logic                 halted_q,  halted_d;
    logic                 rd_valid_q;
    logic [31:0]          rd_data_q, rd_data_d, rd_mux;

    logic                 active, pop, push_ok, push;
    logic                 fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    trace_rec_t           rec_in, head;

    assign active  = enable & ~halted_q & ~clear;
    // A pop coinciding with clear is swallowed by the flush.
    assign pop     = ~fifo_empty & trace_ready & ~clear;
    assign push_ok = ~fifo_full | pop;
    assign push    = active & retire_valid & push_ok;

    assign rec_in.pc     = retire_pc;
    assign rec_in.instr  = retire_instr;
    assign rec_in.branch = branch_taken;

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(trace_rec_t))
    ) u_trace_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (clear),
        .push_i  (push),
        .wdata_i (rec_in),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign trace_valid  = ~fifo_empty;
    assign trace_pc     = head.pc;
    assign trace_instr  = head.instr;
    assign trace_branch = head.branch;

    // Counter and halt next-state; clear beats every increment.
    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        branch_d  = branch_q;
        stall_d   = stall_q;
        drop_d    = drop_q;
        halted_d  = halted_q;
        if (clear) begin
            cycle_d   = '0;
            instret_d = '0;
            branch_d  = '0;
            stall_d   = '0;
            drop_d    = '0;
            halted_d  = 1'b0;
        end else if (active) begin
            cycle_d = cycle_q + CNT_ONE;
            if (retire_valid)             instret_d = instret_q + CNT_ONE;
            if (branch_taken)             branch_d  = branch_q + CNT_ONE;
            if (stall)                    stall_d   = stall_q + CNT_ONE;
            if (retire_valid && !push_ok) drop_d    = drop_q + CNT_ONE;
            if (retire_valid && is_ebreak(retire_instr)) halted_d = 1'b1;
        end
    end

    // Read mux samples pre-edge register values only.
    always_comb begin
        rd_mux = 32'd0;
        case (rd_addr)
            PERF_ADDR_CYCLE:   rd_mux = 32'(cycle_q);
            PERF_ADDR_INSTRET: rd_mux = 32'(instret_q);
            PERF_ADDR_BRANCH:  rd_mux = 32'(branch_q);
            PERF_ADDR_STALL:   rd_mux = 32'(stall_q);
            PERF_ADDR_DROP:    rd_mux = 32'(drop_q);
            PERF_ADDR_OCC:     rd_mux = 32'(fifo_count);
            PERF_ADDR_HALTED:  rd_mux = {31'b0, halted_q};
            PERF_ADDR_ZERO:    rd_mux = 32'd0;
            default:           rd_mux = 32'd0;
        endcase
    end

    assign rd_data_d = rd_en ? rd_mux : rd_data_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q    <= '0;
            instret_q  <= '0;
            branch_q   <= '0;
            stall_q    <= '0;
            drop_q     <= '0;
            halted_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
            branch_q   <= branch_d;
            stall_q    <= stall_d;
            drop_q     <= drop_d;
            halted_q   <= halted_d;
            rd_valid_q <= rd_en;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_perf_trace_unit.sv
module tb_perf_trace_unit;
    import perf_trace_unit_pkg::*;

    localparam int D = 8;

    logic        clock = 1'b0;
    logic        reset_n, enable, clear, retire_valid, branch_taken, stall;
    logic [31:0] retire_pc, retire_instr;
    logic        rd_en, trace_ready;
    logic [2:0]  rd_addr;
    logic        rd_valid, trace_valid, trace_branch, halted;
    logic [31:0] rd_data, trace_pc, trace_instr;
    logic        rd_valid8, trace_valid8, trace_branch8, halted8;
    logic [31:0] rd_data8, trace_pc8, trace_instr8;

    always #5 clock = ~clock;

    perf_trace_unit #(.FIFO_DEPTH(D), .CNT_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .branch_taken(branch_taken), .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_pc(trace_pc), .trace_instr(trace_instr),
        .trace_branch(trace_branch), .halted(halted));

    perf_trace_unit #(.FIFO_DEPTH(D), .CNT_WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .branch_taken(branch_taken), .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid8), .rd_data(rd_data8), .trace_valid(trace_valid8),
        .trace_ready(trace_ready), .trace_pc(trace_pc8), .trace_instr(trace_instr8),
        .trace_branch(trace_branch8), .halted(halted8));

    int checks = 0;
    int errors = 0;

    trace_rec_t exp_q[$];
    bit         m_halted = 1'b0;
    int         branch_recs = 0;
    bit         ebreak_seen = 1'b0;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t tbl[$];

    logic [31:0] d, d8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: score the pre-edge trace head against the expected queue,
    // update the queue for the edge, then advance to #1 after the edge.
    task automatic step();
        bit act, pop, push;
        act  = enable && !m_halted && !clear;
        pop  = (exp_q.size() != 0) && trace_ready && !clear;
        push = act && retire_valid && ((exp_q.size() < D) || pop);
        chk("trace_valid", 32'(trace_valid), 32'(exp_q.size() != 0));
        if (pop) begin
            chk("trace_pc",     trace_pc,            exp_q[0].pc);
            chk("trace_instr",  trace_instr,         exp_q[0].instr);
            chk("trace_branch", 32'(trace_branch),   32'(exp_q[0].branch));
            if (trace_branch) branch_recs++;
            if (trace_instr == EBREAK_ENC) ebreak_seen = 1'b1;
            void'(exp_q.pop_front());
        end
        if (clear) begin
            exp_q.delete();
            m_halted = 1'b0;
        end else begin
            if (push) exp_q.push_back('{pc: retire_pc, instr: retire_instr, branch: branch_taken});
            if (act && retire_valid && retire_instr == EBREAK_ENC) m_halted = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        chk("rd_valid", 32'(rd_valid), 32'd1);
        d  = rd_data;
        d8 = rd_data8;
        rd_en = 1'b0;
    endtask

    task automatic add_vec(input logic [2:0] a, input logic [31:0] e);
        tbl.push_back('{addr: a, exp: e});
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            rd(tbl[i].addr);
            chk($sformatf("%s_rd%0d", tag, tbl[i].addr), d, tbl[i].exp);
        end
        tbl.delete();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; retire_valid = 1'b0;
        retire_pc = '0; retire_instr = '0; branch_taken = 1'b0; stall = 1'b0;
        rd_en = 1'b0; rd_addr = '0; trace_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_trace_valid", 32'(trace_valid), 32'd0);
        chk("rst_halted",      32'(halted),      32'd0);
        chk("rst_rd_valid",    32'(rd_valid),    32'd0);
        chk("rst_rd_data",     rd_data,          32'd0);
        chk("rst_trace_pc",    trace_pc,         32'd0);
        chk("rst_trace_instr", trace_instr,      32'd0);
        chk("rst_trace_branch", 32'(trace_branch), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // 20 idle active cycles
        enable = 1'b1;
        repeat (20) step();
        enable = 1'b0;
        add_vec(3'd0, 32'd20); add_vec(3'd1, 32'd0); add_vec(3'd2, 32'd0);
        add_vec(3'd3, 32'd0);  add_vec(3'd4, 32'd0); add_vec(3'd5, 32'd0);
        add_vec(3'd6, 32'd0);  add_vec(3'd7, 32'd0);
        run_tbl("t1");
        step();
        chk("t1_rd_valid_drop", 32'(rd_valid), 32'd0);

        // Loop stimulus: 32 retires, 8 branches, 3 stalls
        do_clear();
        enable = 1'b1; trace_ready = 1'b1; branch_recs = 0;
        for (int i = 0; i < 32; i++) begin
            retire_valid = 1'b1;
            retire_pc    = 32'h1000 + 32'(i) * 4;
            retire_instr = 32'h13 | (32'(i) << 7);
            branch_taken = (i % 4 == 3);
            stall        = (i == 5 || i == 13 || i == 21);
            step();
        end
        retire_valid = 1'b0; branch_taken = 1'b0; stall = 1'b0; enable = 1'b0;
        repeat (3) step();
        chk("t2_branch_records", 32'(branch_recs), 32'd8);
        add_vec(3'd0, 32'd32); add_vec(3'd1, 32'd32); add_vec(3'd2, 32'd8);
        add_vec(3'd3, 32'd3);  add_vec(3'd4, 32'd0);  add_vec(3'd5, 32'd0);
        run_tbl("t2");

        // Back-pressure: 12 retires into depth 8
        do_clear();
        enable = 1'b1; trace_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            retire_valid = 1'b1;
            retire_pc    = 32'h3000 + 32'(i) * 4;
            retire_instr = 32'h00000093 | (32'(i) << 20);
            step();
            chk("t3_head_hold", trace_pc, 32'h3000);
        end
        retire_valid = 1'b0;
        add_vec(3'd5, 32'd8); add_vec(3'd4, 32'd4); add_vec(3'd1, 32'd12);
        run_tbl("t3");
        trace_ready = 1'b1; retire_valid = 1'b1;
        retire_pc = 32'h3100; retire_instr = 32'h00500093;
        step();
        retire_valid = 1'b0; trace_ready = 1'b0;
        add_vec(3'd5, 32'd8); add_vec(3'd4, 32'd4);
        run_tbl("t3_fullpp");
        trace_ready = 1'b1;
        repeat (10) step();
        chk("t3_drained", 32'(trace_valid), 32'd0);

        // EBREAK at cycle 40
        enable = 1'b1; trace_ready = 1'b1; ebreak_seen = 1'b0;
        do_clear();
        repeat (40) step();
        retire_valid = 1'b1; retire_pc = 32'h4000; retire_instr = EBREAK_ENC;
        step();
        chk("t4_halted", 32'(halted), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            retire_pc = 32'h4000 + 32'(i) * 4; retire_instr = 32'h13;
            step();
        end
        retire_valid = 1'b0;
        repeat (2) step();
        chk("t4_ebreak_delivered", 32'(ebreak_seen), 32'd1);
        add_vec(3'd0, 32'd41); add_vec(3'd1, 32'd1); add_vec(3'd6, 32'd1);
        add_vec(3'd5, 32'd0);  add_vec(3'd4, 32'd0);
        run_tbl("t4");

        // Clear beats same-cycle retire/branch
        trace_ready = 1'b0;
        clear = 1'b1; retire_valid = 1'b1; branch_taken = 1'b1;
        retire_pc = 32'h5000; retire_instr = 32'h13;
        step();
        clear = 1'b0; retire_valid = 1'b0; branch_taken = 1'b0;
        chk("t5_halted", 32'(halted), 32'd0);
        chk("t5_empty",  32'(trace_valid), 32'd0);
        retire_valid = 1'b1; retire_pc = 32'h5004;
        step();
        retire_valid = 1'b0; enable = 1'b0;
        add_vec(3'd0, 32'd1); add_vec(3'd1, 32'd1); add_vec(3'd2, 32'd0);
        add_vec(3'd3, 32'd0); add_vec(3'd4, 32'd0); add_vec(3'd5, 32'd1);
        add_vec(3'd6, 32'd0);
        run_tbl("t5");
        trace_ready = 1'b1;
        repeat (2) step();

        // 8-bit wrap, then asynchronous reset mid-stream
        do_clear();
        enable = 1'b1;
        repeat (260) step();
        enable = 1'b0;
        rd(3'd0);
        chk("t6_cycle32", d,  32'd260);
        chk("t6_cycle8",  d8, 32'd4);
        trace_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            retire_valid = 1'b1; retire_pc = 32'h6000 + 32'(i) * 4; retire_instr = 32'h13;
            step();
        end
        retire_valid = 1'b0; enable = 1'b0;
        chk("t6_pre_valid", 32'(trace_valid), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid",  32'(trace_valid),  32'd0);
        chk("t6_rst_valid8", 32'(trace_valid8), 32'd0);
        chk("t6_rst_pc",     trace_pc,          32'd0);
        exp_q.delete();
        m_halted = 1'b0;
        @(posedge clock); #1;
        chk("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) add_vec(3'(a), 32'd0);
        run_tbl("t6");
        rd(3'd0);
        chk("t6_cycle8_rst", d8, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
